// File: rtl/reg_display_ctrl.sv
// On-screen register viewer: snapshots NREGS 16-bit registers per frame and scans them
// into a 32-pixel-wide window as rows of 4 hex digits via an external glyph datapath.
module reg_display_ctrl #(
    parameter logic [9:0] X0    = 10'd64,
    parameter logic [9:0] Y0    = 10'd48,
    parameter int         NREGS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            hpos,
    input  logic [9:0]            vpos,
    input  logic                  frame_start,
    input  logic                  freeze,
    input  logic [NREGS*16-1:0]   reg_in,
    output logic [15:0]           glyph_reg,
    output logic [2:0]            glyph_line,
    output logic [4:0]            glyph_col,
    input  logic                  glyph_pixel,
    output logic                  pix_out,
    output logic                  pix_valid
);

    localparam logic [10:0] X_END = {1'b0, X0} + 11'd32;
    localparam logic [10:0] Y_END = {1'b0, Y0} + 11'(NREGS * 10);

    typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

    state_t      r_state, w_state_nxt;
    logic        w_snap;
    logic [15:0] r_shadow [NREGS];
    logic [3:0]  r_row, r_sub;
    logic [15:0] w_cur_reg;
    logic        w_hin, w_vin, w_win;
    logic [4:0]  w_hcol;
    logic [15:0] r_glyph_reg;
    logic [2:0]  r_glyph_line;
    logic [4:0]  r_glyph_col;
    logic        r_in_win, r_win_d1;
    logic        r_pix_out, r_pix_valid;

    // The first frame_start always snapshots, later ones only when not frozen.
    always_comb begin
        w_state_nxt = r_state;
        w_snap      = 1'b0;
        if (frame_start) begin
            w_state_nxt = ACTIVE;
            w_snap      = (r_state == WAIT_FRAME) || !freeze;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= WAIT_FRAME;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) r_shadow[k] <= 16'd0;
        end else if (w_snap) begin
            for (int k = 0; k < NREGS; k++) r_shadow[k] <= reg_in[16*k +: 16];
        end
    end

    assign w_hin  = ({1'b0, hpos} >= {1'b0, X0}) && ({1'b0, hpos} < X_END);
    assign w_vin  = ({1'b0, vpos} >= {1'b0, Y0}) && ({1'b0, vpos} < Y_END);
    assign w_win  = w_hin && w_vin;
    // Low 5 bits of hpos-X0; out-of-window wrap is masked by in_win downstream.
    assign w_hcol = hpos[4:0] - X0[4:0];

    // Row/sub-line tracked incrementally at the start of each line instead of dividing vpos.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row <= 4'd0;
            r_sub <= 4'd0;
        end else if (hpos == 10'd0) begin
            if (vpos == Y0) begin
                r_row <= 4'd0;
                r_sub <= 4'd0;
            end else if (w_vin) begin
                if (r_sub == 4'd9) begin
                    r_sub <= 4'd0;
                    r_row <= r_row + 4'd1;
                end else begin
                    r_sub <= r_sub + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_cur_reg = 16'd0;
        for (int k = 0; k < NREGS; k++)
            if (r_row == 4'(k)) w_cur_reg = r_shadow[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_glyph_reg  <= 16'd0;
            r_glyph_line <= 3'd0;
            r_glyph_col  <= 5'd0;
            r_in_win     <= 1'b0;
            r_win_d1     <= 1'b0;
            r_pix_out    <= 1'b0;
            r_pix_valid  <= 1'b0;
        end else begin
            r_glyph_reg  <= w_cur_reg;
            r_glyph_line <= r_sub[2:0];
            r_glyph_col  <= w_hcol;
            r_in_win     <= w_win && (r_sub < 4'd8) && (r_state == ACTIVE);
            r_win_d1     <= w_win;
            r_pix_out    <= glyph_pixel & r_in_win;
            r_pix_valid  <= r_win_d1;
        end
    end

    assign glyph_reg  = r_glyph_reg;
    assign glyph_line = r_glyph_line;
    assign glyph_col  = r_glyph_col;
    assign pix_out    = r_pix_out;
    assign pix_valid  = r_pix_valid;

endmodule

// File: tb/tb_reg_display_ctrl.sv
// Directed bench for reg_display_ctrl: scans full frames with a simple glyph model and
// checks every pixel plus hand-computed probe points.
module tb_reg_display_ctrl;

    localparam logic [9:0] X0 = 10'd64;
    localparam logic [9:0] Y0 = 10'd48;
    localparam int NR = 8;
    localparam int NL = NR * 10;

    logic            clk, reset, frame_start, freeze, glyph_pixel, pix_out, pix_valid;
    logic [9:0]      hpos, vpos;
    logic [NR*16-1:0] reg_in;
    logic [15:0]     glyph_reg;
    logic [2:0]      glyph_line;
    logic [4:0]      glyph_col;

    int checks = 0;
    int errors = 0;

    logic        m_active;
    logic [15:0] m_sh [NR];
    logic        e_pix, e_vld;

    logic [15:0] c_reg  [NL];
    logic [2:0]  c_line [NL];
    logic [4:0]  c_col  [NL];
    logic        c_pix  [NL];
    logic        c_vld  [NL];
    logic [15:0] f_old, f_new;

    reg_display_ctrl #(.X0(X0), .Y0(Y0), .NREGS(NR)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .frame_start(frame_start), .freeze(freeze), .reg_in(reg_in),
        .glyph_reg(glyph_reg), .glyph_line(glyph_line), .glyph_col(glyph_col),
        .glyph_pixel(glyph_pixel), .pix_out(pix_out), .pix_valid(pix_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign glyph_pixel = glyph_reg[glyph_col[3:0]] ^ glyph_line[0];

    function automatic logic gpm(logic [15:0] r, logic [2:0] l, logic [4:0] c);
        return r[c[3:0]] ^ l[0];
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step(int h, int v, logic fs, logic rst);
        logic hw, vw, inw, npix, nvld;
        int off, row, sub;
        logic [15:0] ereg;
        logic [2:0]  eline;
        logic [4:0]  ecol;
        hpos = 10'(h); vpos = 10'(v); frame_start = fs; reset = rst;
        hw  = (h >= int'(X0)) && (h < int'(X0) + 32);
        vw  = (v >= int'(Y0)) && (v < int'(Y0) + NL);
        off = v - int'(Y0);
        row = vw ? off / 10 : 0;
        sub = vw ? off % 10 : 0;
        ereg  = m_sh[row];
        eline = 3'(sub);
        ecol  = 5'(h - int'(X0));
        inw   = hw && vw && (sub < 8) && m_active;
        npix  = inw ? gpm(ereg, eline, ecol) : 1'b0;
        nvld  = hw && vw;
        @(posedge clk); #1;
        if (rst) begin
            chk("rst_greg", glyph_reg, 0);
            chk("rst_gline", glyph_line, 0);
            chk("rst_gcol", glyph_col, 0);
            chk("rst_pix", pix_out, 0);
            chk("rst_vld", pix_valid, 0);
            m_active = 1'b0;
            for (int k = 0; k < NR; k++) m_sh[k] = 16'd0;
            e_pix = 1'b0;
            e_vld = 1'b0;
        end else begin
            chk("pix", pix_out, e_pix);
            chk("vld", pix_valid, e_vld);
            if (hw && vw && m_active) begin
                chk("greg", glyph_reg, ereg);
                chk("gline", glyph_line, eline);
                chk("gcol", glyph_col, ecol);
            end
            e_pix = npix;
            e_vld = nvld;
            if (fs) begin
                if (!m_active || !freeze)
                    for (int k = 0; k < NR; k++) m_sh[k] = reg_in[16*k +: 16];
                m_active = 1'b1;
            end
        end
    endtask

    task automatic line(int v, int fs_h, int rst_h);
        int off;
        off = v - int'(Y0);
        step(0, v, fs_h == 0, rst_h == 0);
        for (int h = int'(X0) - 3; h <= int'(X0) + 34; h++) begin
            step(h, v, fs_h == h, rst_h == h);
            if (off >= 0 && off < NL) begin
                if (h == int'(X0) + 2) begin
                    c_reg[off]  = glyph_reg;
                    c_line[off] = glyph_line;
                    c_col[off]  = glyph_col;
                end
                if (h == int'(X0) + 3) begin
                    c_pix[off] = pix_out;
                    c_vld[off] = pix_valid;
                end
            end
            if (fs_h > 0 && h == fs_h)     f_old = glyph_reg;
            if (fs_h > 0 && h == fs_h + 1) f_new = glyph_reg;
        end
    endtask

    task automatic frame(logic fs, int fs_v, int fs_h, int rst_v, int rst_h);
        step(0, 0, fs, 1'b0);
        for (int v = int'(Y0) - 1; v <= int'(Y0) + NL; v++)
            line(v, (v == fs_v) ? fs_h : -1, (v == rst_v) ? rst_h : -1);
    endtask

    initial begin
        freeze = 1'b0; frame_start = 1'b0; reset = 1'b1; hpos = '0; vpos = '0;
        m_active = 1'b0; e_pix = 1'b0; e_vld = 1'b0;
        for (int k = 0; k < NR; k++) m_sh[k] = 16'd0;
        for (int k = 0; k < NR; k++) reg_in[16*k +: 16] = 16'(16'h1111 * k);
        reg_in[15:0]  = 16'h1234;
        reg_in[31:16] = 16'h5A5A;
        reg_in[47:32] = 16'hC3C3;

        // reset wins over a coincident frame_start
        step(0, 0, 1'b0, 1'b1);
        step(0, 0, 1'b1, 1'b1);

        frame(1'b0, -1, -1, -1, -1);
        chk("nofs_pix0", c_pix[0], 0);
        chk("nofs_vld0", c_vld[0], 1);
        chk("nofs_vld79", c_vld[79], 1);

        frame(1'b1, -1, -1, -1, -1);
        chk("r0_reg", c_reg[0], 16'h1234);
        chk("r0_line", c_line[0], 0);
        chk("r0_col", c_col[0], 2);
        chk("r0_pix", c_pix[0], 1);
        chk("r0_l3_line", c_line[3], 3);
        chk("r0_l3_pix", c_pix[3], 0);
        chk("r1_reg", c_reg[10], 16'h5A5A);
        chk("r1_line", c_line[10], 0);
        chk("gap_reg", c_reg[18], 16'h5A5A);
        chk("gap_pix", c_pix[18], 0);
        chk("gap_vld", c_vld[18], 1);
        chk("r2_reg", c_reg[20], 16'hC3C3);
        chk("r2_line", c_line[20], 0);
        chk("r7_reg", c_reg[79], 16'h7777);

        freeze = 1'b1;
        reg_in[15:0] = 16'hBEEF;
        frame(1'b1, -1, -1, -1, -1);
        chk("frz_reg", c_reg[0], 16'h1234);
        freeze = 1'b0;
        frame(1'b1, -1, -1, -1, -1);
        chk("unfrz_reg", c_reg[0], 16'hBEEF);
        chk("unfrz_pix", c_pix[0], 1);

        reg_in[15:0] = 16'h0F0F;
        frame(1'b0, int'(Y0) + 2, int'(X0) + 5, -1, -1);
        chk("fs_old", f_old, 16'hBEEF);
        chk("fs_new", f_new, 16'h0F0F);

        frame(1'b0, -1, -1, int'(Y0) + 5, int'(X0) + 10);
        chk("rstmid_pix", c_pix[40], 0);
        chk("rstmid_vld", c_vld[40], 1);
        frame(1'b1, -1, -1, -1, -1);
        chk("post_reg", c_reg[0], 16'h0F0F);
        chk("post_pix", c_pix[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
